// File: rtl/imem_backing_responder_pkg.sv
// Shared state encodings, word geometry and byte-merge helper for the backing-memory responder.
package imem_backing_responder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int WORD_BYTES = 4;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/imem_word_array.sv
// DEPTH x 32 single-port storage with per-byte write enables and a write-first registered read.
module imem_word_array
    import imem_backing_responder_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= 32'h0;
        end else if (en) begin
            rdata <= merge_bytes(mem[addr], wdata, be);
        end
    end

endmodule

// File: rtl/imem_backing_responder.sv
// Backing-memory responder for cache refills/writebacks with fixed LATENCY.
// Optional address range check enabled by defining RANGE_CHECK_EN.
module imem_backing_responder
    import imem_backing_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wen_q, err_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              resp_valid_q, resp_err_q;
    logic              go_resp, in_idle, req_err;
    logic              acc_wen, acc_err, arr_en;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata, arr_rdata;
    logic [3:0]        acc_be, arr_be;

`ifdef RANGE_CHECK_EN
    assign req_err = |req_addr[31:ADDR_W+2];
    logic unused_addr;
    assign unused_addr = ^req_addr[1:0];
`else
    assign req_err = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

    assign in_idle = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY==1 the array access coincides with the accept edge, so bypass the latches.
    assign acc_idx   = in_idle ? req_addr[ADDR_W+1:2] : idx_q;
    assign acc_wdata = in_idle ? req_wdata : wdata_q;
    assign acc_be    = in_idle ? req_be : be_q;
    assign acc_wen   = in_idle ? req_wen : wen_q;
    assign acc_err   = in_idle ? req_err : err_q;
    assign arr_en    = go_resp & ~acc_err;
    assign arr_be    = acc_wen ? acc_be : 4'b0000;

    imem_word_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (arr_en),
        .addr  (acc_idx),
        .wdata (acc_wdata),
        .be    (arr_be),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            wen_q        <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= go_resp;
            if (in_idle && req_valid) begin
                wen_q   <= req_wen;
                err_q   <= req_err;
                idx_q   <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (go_resp) resp_err_q <= acc_err;
        end
    end

    assign req_ready  = in_idle;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_err_q ? 32'h0 : arr_rdata;

endmodule

// File: tb/tb_imem_backing_responder.sv
// Directed self-checking bench: LATENCY=3 main instance plus a LATENCY=1 instance.
module tb_imem_backing_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_wen = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        l1_req_valid = 1'b0, l1_req_wen = 1'b0;
    logic [31:0] l1_req_addr = 32'h0, l1_req_wdata = 32'h0;
    logic [3:0]  l1_req_be = 4'h0;
    logic        l1_req_ready, l1_resp_valid, l1_resp_err;
    logic [31:0] l1_resp_rdata;

    int n_vec = 0;
    int n_err = 0;

    localparam int LAT = 3;

    always #5 clk = ~clk;

    imem_backing_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    imem_backing_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1)) dut_l1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (l1_req_valid),
        .req_ready  (l1_req_ready),
        .req_wen    (l1_req_wen),
        .req_addr   (l1_req_addr),
        .req_wdata  (l1_req_wdata),
        .req_be     (l1_req_be),
        .resp_valid (l1_resp_valid),
        .resp_rdata (l1_resp_rdata),
        .resp_err   (l1_resp_err)
    );

    // One transaction on the main instance; cycle 1 is the cycle right after the accept edge.
    task automatic do_req(input string name, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int cyc;
        logic [31:0] rd;
        logic er;
        cyc = 0;
        rd = 32'h0;
        er = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_before: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        @(negedge clk);
        // Request inputs must be ignored once accepted.
        req_valid = 1'b0;
        req_wen   = ~wen;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'h5555_5555;
        req_be    = 4'hF;
        for (int k = 1; k <= 20; k++) begin
            n_vec++;
            if (req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s ready_busy: cycle %0d got %b want 0", name, k, req_ready);
            end
            if (resp_valid === 1'b1) begin
                cyc = k;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (cyc != LAT) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, LAT);
        end
        n_vec++;
        if (rd !== exp_rdata || er !== exp_err) begin
            n_err++;
            $display("FAIL %s resp: got rdata=%h err=%b want rdata=%h err=%b",
                     name, rd, er, exp_rdata, exp_err);
        end
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL %s after_resp: got valid=%b ready=%b rdata=%h want 0 1 %h",
                     name, resp_valid, req_ready, resp_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
            resp_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        reset = 1'b1;
    endtask

    task automatic test_full_write;
        do_req("wr_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_partial_merge;
        do_req("wr_merge", 1'b1, 32'h10, 32'h0000_1122, 4'b0011, 32'hDEAD_1122, 1'b0);
        do_req("rd_merge", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_1122, 1'b0);
        do_req("rd_alias_lsb", 1'b0, 32'h12, 32'h0, 4'h0, 32'hDEAD_1122, 1'b0);
        do_req("wr_be0", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'hDEAD_1122, 1'b0);
        do_req("wr_be_hi", 1'b1, 32'h10, 32'hAB00_0000, 4'b1000, 32'hABAD_1122, 1'b0);
    endtask

    task automatic test_back_to_back;
        int acc_at[2];
        int nacc, npulse;
        logic prev_v, chg, dbl;
        logic [31:0] pdata[2];
        do_req("seed0", 1'b1, 32'h0, 32'hA5A5_0000, 4'hF, 32'hA5A5_0000, 1'b0);
        do_req("seed4", 1'b1, 32'h4, 32'h0000_5A5A, 4'hF, 32'h0000_5A5A, 1'b0);
        nacc = 0;
        npulse = 0;
        prev_v = 1'b0;
        chg = 1'b0;
        dbl = 1'b0;
        acc_at[0] = 0;
        acc_at[1] = 0;
        pdata[0] = 32'h0;
        pdata[1] = 32'h0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h0;
        req_be    = 4'h0;
        for (int c = 0; c < 16; c++) begin
            if (chg) begin
                if (nacc == 1) req_addr = 32'h4;
                else req_valid = 1'b0;
                chg = 1'b0;
            end
            if (resp_valid === 1'b1) begin
                if (prev_v) dbl = 1'b1;
                if (npulse < 2) pdata[npulse] = resp_rdata;
                npulse++;
            end
            prev_v = resp_valid;
            if (req_valid && req_ready === 1'b1) begin
                if (nacc < 2) acc_at[nacc] = c;
                nacc++;
                chg = 1'b1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_vec++;
        if (nacc != 2 || acc_at[1] - acc_at[0] != LAT + 1) begin
            n_err++;
            $display("FAIL b2b_spacing: got accepts=%0d gap=%0d want 2 %0d",
                     nacc, acc_at[1] - acc_at[0], LAT + 1);
        end
        n_vec++;
        if (npulse != 2 || dbl) begin
            n_err++;
            $display("FAIL b2b_pulses: got pulses=%0d wide=%b want 2 0", npulse, dbl);
        end
        n_vec++;
        if (pdata[0] !== 32'hA5A5_0000 || pdata[1] !== 32'h0000_5A5A) begin
            n_err++;
            $display("FAIL b2b_data: got %h %h want a5a50000 00005a5a", pdata[0], pdata[1]);
        end
    endtask

    task automatic test_reset_mid_wait;
        int seen;
        seen = 0;
        do_req("seed20", 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 32'h0BAD_F00D, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        req_be    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL mid_wait_reset: got resps=%0d ready=%b rdata=%h want 0 1 0",
                     seen, req_ready, resp_rdata);
        end
        do_req("rd_after_reset", 1'b0, 32'h20, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_latency1;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            l1_req_valid = 1'b1;
            l1_req_wen   = (t == 0);
            l1_req_addr  = 32'h8;
            l1_req_wdata = 32'h600D_CAFE;
            l1_req_be    = 4'hF;
            @(posedge clk);
            @(negedge clk);
            l1_req_valid = 1'b0;
            n_vec++;
            if (l1_resp_valid !== 1'b1 || l1_resp_rdata !== 32'h600D_CAFE ||
                l1_req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL lat1_resp%0d: got valid=%b rdata=%h ready=%b want 1 600dcafe 0",
                         t, l1_resp_valid, l1_resp_rdata, l1_req_ready);
            end
            @(negedge clk);
            n_vec++;
            if (l1_resp_valid !== 1'b0 || l1_req_ready !== 1'b1) begin
                n_err++;
                $display("FAIL lat1_after%0d: got valid=%b ready=%b want 0 1",
                         t, l1_resp_valid, l1_req_ready);
            end
        end
    endtask

    task automatic test_range;
        do_req("seed_w0", 1'b1, 32'h0, 32'h1111_2222, 4'hF, 32'h1111_2222, 1'b0);
`ifdef RANGE_CHECK_EN
        do_req("wr_oor", 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1);
        do_req("rd_w0_kept", 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111_2222, 1'b0);
`else
        do_req("wr_alias", 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 1'b0);
        do_req("rd_w0_alias", 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_partial_merge();
        test_back_to_back();
        test_reset_mid_wait();
        test_latency1();
        test_range();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
